// File: rtl/src_phase_sequencer.sv
// -----------------------------------------------------------------------------
// src_phase_sequencer
//
// Control sequencer for the 160/147 polyphase sample-rate converter. An
// incremental phase accumulator (phase += M, wrap at L) replaces the
// (n*M) % L datapath arithmetic. A wrap means a new input sample is needed
// before the next output, so the sequencer goes through FETCH first.
// Each output walks TAPS MAC steps, issuing coefficient addresses and tap
// selects. The MAC/delay-line datapath therefore contains no control logic.
//
// Optional feature macro: SRC_SEQ_DRAIN_EN
//   Defined   : one DRAIN cycle (mac_en=0) follows the last tap. This suits a
//               datapath whose product register adds a cycle before
//               accumulation.
//   Undefined : OUTPUT follows the last tap directly.
//
// Handshakes (both sides): the req output is a registered level. Once raised,
// it holds until the matching ack is sampled high on a rising clock edge. It
// drops on the following cycle. An ack seen while its req is low is ignored.
// An ack held high counts only once, because req has already dropped.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   en         run enable, sampled only in IDLE and ADVANCE
//   in_req     request for the next input sample (registered)
//   in_ack     input sample valid
//   shift_en   delay-line shift strobe = in_req & in_ack (combinational)
//   mac_clr    accumulator load on tap 0 (registered)
//   mac_en     MAC step valid (registered)
//   mac_tap    delay-line tap select 0..TAPS-1 (registered)
//   coef_addr  coefficient ROM address = phase + tap*L (registered)
//   out_req    accumulator result valid (registered)
//   out_ack    output consumer accepted the result
//   phase      current polyphase branch
//   out_cnt    outputs delivered, wraps 0xFFFF -> 0
//   state_dbg  current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module src_phase_sequencer #(
    parameter int L       = 160,
    parameter int M       = 147,
    parameter int TAPS    = 4,
    parameter int PH_W    = 8,
    parameter int CADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               in_req,
    input  logic               in_ack,
    output logic               shift_en,
    output logic               mac_clr,
    output logic               mac_en,
    output logic [1:0]         mac_tap,
    output logic [CADDR_W-1:0] coef_addr,
    output logic               out_req,
    input  logic               out_ack,
    output logic [PH_W-1:0]    phase,
    output logic [15:0]        out_cnt,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_MAC     = 3'd2,
        S_DRAIN   = 3'd3,
        S_OUTPUT  = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    localparam logic [1:0]  TAP_LAST = 2'(TAPS - 1);
    localparam logic [PH_W:0] M_EXT  = (PH_W+1)'(M);
    localparam logic [PH_W:0] L_EXT  = (PH_W+1)'(L);

    state_t               state_q,   state_d;
    logic [PH_W-1:0]      phase_q,   phase_d;
    logic [15:0]          out_cnt_q, out_cnt_d;
    logic [1:0]           tap_q,     tap_d;
    logic [CADDR_W-1:0]   coef_q,    coef_d;
    logic                 in_req_q,  in_req_d;
    logic                 out_req_q, out_req_d;
    logic                 mac_en_q,  mac_en_d;
    logic                 mac_clr_q, mac_clr_d;

    // One extra bit so phase + M never overflows before the wrap compare.
    logic [PH_W:0]        sum;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        out_cnt_d = out_cnt_q;
        tap_d     = '0;
        coef_d    = '0;
        sum       = {1'b0, phase_q} + M_EXT;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (in_ack) begin
                    state_d = S_MAC;
                    coef_d  = CADDR_W'(phase_q);
                end
            end
            S_MAC: begin
                if (tap_q == TAP_LAST) begin
`ifdef SRC_SEQ_DRAIN_EN
                    state_d = S_DRAIN;
`else
                    state_d = S_OUTPUT;
`endif
                end else begin
                    // Step the address by L per tap instead of multiplying.
                    tap_d  = tap_q + 2'd1;
                    coef_d = coef_q + CADDR_W'(L);
                end
            end
`ifdef SRC_SEQ_DRAIN_EN
            S_DRAIN: begin
                state_d = S_OUTPUT;
            end
`endif
            S_OUTPUT: begin
                if (out_ack) begin
                    out_cnt_d = out_cnt_q + 16'd1;
                    state_d   = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                // Phase moves only when en allows it. A wrap past L means the
                // next output needs a fresh input sample. M < L guarantees at
                // most one wrap.
                if (en) begin
                    if (sum >= L_EXT) begin
                        phase_d = PH_W'(sum - L_EXT);
                        state_d = S_FETCH;
                    end else begin
                        phase_d = sum[PH_W-1:0];
                        coef_d  = CADDR_W'(sum[PH_W-1:0]);
                        state_d = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they line up with
        // the state register.
        in_req_d  = (state_d == S_FETCH);
        out_req_d = (state_d == S_OUTPUT);
        mac_en_d  = (state_d == S_MAC);
        mac_clr_d = (state_d == S_MAC) && (tap_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            out_cnt_q <= '0;
            tap_q     <= '0;
            coef_q    <= '0;
            in_req_q  <= 1'b0;
            out_req_q <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            out_cnt_q <= out_cnt_d;
            tap_q     <= tap_d;
            coef_q    <= coef_d;
            in_req_q  <= in_req_d;
            out_req_q <= out_req_d;
            mac_en_q  <= mac_en_d;
            mac_clr_q <= mac_clr_d;
        end
    end

    assign in_req    = in_req_q;
    assign shift_en  = in_req_q & in_ack;
    assign out_req   = out_req_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign mac_tap   = tap_q;
    assign coef_addr = coef_q;
    assign phase     = phase_q;
    assign out_cnt   = out_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_src_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for src_phase_sequencer.
// The reference model describes output n in closed form:
//   - its polyphase branch is (n*M) % L;
//   - it needs a fresh input iff n == 0 or floor(n*M/L) advanced since n-1;
//   - its tap k uses coefficient address branch + k*L.
// A negedge compare process checks the DUT against that model on every cycle.
// Directed tests add hand-computed literals.
// -----------------------------------------------------------------------------
module tb_src_phase_sequencer;

    localparam int L       = 160;
    localparam int M       = 147;
    localparam int TAPS    = 4;
    localparam int PH_W    = 8;
    localparam int CADDR_W = 10;
`ifdef SRC_SEQ_DRAIN_EN
    localparam int DRAIN_CYC = 1;
`else
    localparam int DRAIN_CYC = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               in_ack = 1'b0;
    logic               out_ack = 1'b0;
    logic               in_req, shift_en, mac_clr, mac_en, out_req;
    logic [1:0]         mac_tap;
    logic [CADDR_W-1:0] coef_addr;
    logic [PH_W-1:0]    phase;
    logic [15:0]        out_cnt;
    logic [2:0]         state_dbg;

    always #5 clk = ~clk;

    src_phase_sequencer #(
        .L(L), .M(M), .TAPS(TAPS), .PH_W(PH_W), .CADDR_W(CADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_req(in_req), .in_ack(in_ack), .shift_en(shift_en),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_tap(mac_tap),
        .coef_addr(coef_addr), .out_req(out_req), .out_ack(out_ack),
        .phase(phase), .out_cnt(out_cnt), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int exp_phase(input int n);
        return (n * M) % L;
    endfunction

    function automatic bit need_fetch(input int n);
        if (n == 0) return 1'b1;
        return ((n * M) / L) != (((n - 1) * M) / L);
    endfunction

    // ---------------- ack driver ----------------
    // mode 0: manual values, 1: tied high, 2: random (also while req is low)
    int   ack_mode = 0;
    logic man_in   = 1'b0;
    logic man_out  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0: begin in_ack = man_in; out_ack = man_out; end
                1: begin in_ack = 1'b1;   out_ack = 1'b1;    end
                default: begin
                    in_ack  = ($urandom_range(0, 2) == 0);
                    out_ack = ($urandom_range(0, 2) == 0);
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    int   mn = 0;          // outputs delivered since reset
    int   mk = 0;          // MAC taps seen for the current output
    bit   mfetched = 1'b0; // input fetched for the current output
    int   shifts = 0;
    int   shifts_160 = -1;
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   rst_prev = 1'b0;
    logic p_in_req = 1'b0, p_in_ack = 1'b0, p_out_req = 1'b0, p_out_ack = 1'b0;

    int phase_log[8];
    int fetch_log[8];
    int coef_log[8][4];
    int shift_cyc_log[8];
    int mac_start_log[8];
    int out_rise_log[8];
    int out_hs_log[8];
    int in_rise_log[8];

    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            check("rst_in_req",    in_req,    0);
            check("rst_out_req",   out_req,   0);
            check("rst_mac_en",    mac_en,    0);
            check("rst_mac_clr",   mac_clr,   0);
            check("rst_mac_tap",   mac_tap,   0);
            check("rst_coef_addr", coef_addr, 0);
            check("rst_phase",     phase,     0);
            check("rst_out_cnt",   out_cnt,   0);
            check("rst_shift_en",  shift_en,  0);
        end else if (armed) begin
            check("shift_en", shift_en, in_req & in_ack);
            if (p_in_req && !p_in_ack)  check("in_req_hold",  in_req,  1);
            if (p_in_req && p_in_ack)   check("in_req_drop",  in_req,  0);
            if (p_out_req && !p_out_ack) check("out_req_hold", out_req, 1);
            if (p_out_req && p_out_ack)  check("out_req_drop", out_req, 0);

            if (in_req && !p_in_req && mn < 8) in_rise_log[mn] = cyc;
            if (out_req && !p_out_req && mn < 8) out_rise_log[mn] = cyc;

            if (in_req && in_ack) begin
                check("fetch_outside_mac", mk, 0);
                check("single_fetch", mfetched, 0);
                mfetched = 1'b1;
                shifts++;
                if (mn < 8) shift_cyc_log[mn] = cyc;
            end

            if (mac_en) begin
                check("mac_tap",   mac_tap,   mk);
                check("mac_clr",   mac_clr,   (mk == 0));
                check("mac_phase", phase,     exp_phase(mn));
                check("coef_addr", coef_addr, exp_phase(mn) + mk * L);
                if (mk == 0) begin
                    check("fetch_needed", mfetched, need_fetch(mn));
                    if (mn < 8) mac_start_log[mn] = cyc;
                end
                if (mn < 8 && mk < 4) coef_log[mn][mk] = coef_addr;
                mk++;
            end

            if (out_req && out_ack) begin
                check("taps_done",  mk,      TAPS);
                check("out_cnt",    out_cnt, mn % 65536);
                check("out_phase",  phase,   exp_phase(mn));
                if (mn < 8) begin
                    phase_log[mn]  = phase;
                    fetch_log[mn]  = mfetched;
                    out_hs_log[mn] = cyc;
                end
                mn++;
                mk = 0;
                mfetched = 1'b0;
                if (mn == L) shifts_160 = shifts;
            end
        end

        if (rst) begin
            mn = 0; mk = 0; mfetched = 1'b0; shifts = 0; shifts_160 = -1;
            armed = 1'b1;
        end
        rst_prev  = rst;
        p_in_req  = in_req;
        p_in_ack  = in_ack;
        p_out_req = out_req;
        p_out_ack = out_ack;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic wait_outs(input int target, input int budget, input string name);
        int i = 0;
        while (mn < target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, (mn >= target), 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int ph;
        int i;

        // Reset: 3 cycles with en high.
        ack_mode = 0; man_in = 0; man_out = 0; en = 1'b1; rst = 1'b1;
        tick(3);
        check("t1_in_req_rst",  in_req,  0);
        check("t1_phase_rst",   phase,   0);
        check("t1_out_cnt_rst", out_cnt, 0);
        rst = 1'b0;
        check("t1_in_req_release", in_req, 0);
        tick(1);
        check("t1_in_req_rise", in_req, 1);

        // First outputs with acks tied high.
        ack_mode = 1;
        wait_outs(5, 200, "t2_timeout");
        check("t2_phase0", phase_log[0], 0);
        check("t2_phase1", phase_log[1], 147);
        check("t2_phase2", phase_log[2], 134);
        check("t2_phase3", phase_log[3], 121);
        check("t2_phase4", phase_log[4], 108);
        check("t2_fetch0", fetch_log[0], 1);
        check("t2_fetch1", fetch_log[1], 0);
        check("t2_fetch2", fetch_log[2], 1);
        check("t2_fetch3", fetch_log[3], 1);
        check("t2_fetch4", fetch_log[4], 1);
        check("t2_coef2_0", coef_log[2][0], 134);
        check("t2_coef2_1", coef_log[2][1], 294);
        check("t2_coef2_2", coef_log[2][2], 454);
        check("t2_coef2_3", coef_log[2][3], 614);
        check("t2_lat_shift_mac", mac_start_log[0] - shift_cyc_log[0], 1);
        check("t2_lat_shift_out", out_rise_log[0] - shift_cyc_log[0], TAPS + 1 + DRAIN_CYC);
        check("t2_lat_nofetch",   mac_start_log[1] - out_hs_log[0], 2);
        check("t2_lat_fetch",     in_rise_log[2] - out_hs_log[1], 2);

        // Full period with random ack delays.
        ack_mode = 2;
        do_reset();
        wait_outs(L, 6000, "t3_timeout");
        ack_mode = 0; man_in = 0; man_out = 0;
        tick(1);
        check("t3_shifts",  shifts_160, M);
        check("t3_phase",   phase,      0);
        check("t3_out_cnt", out_cnt,    L);

        // Backpressure on out_ack, then on in_ack.
        ack_mode = 0; man_in = 1; man_out = 0;
        do_reset();
        i = 0;
        while (!out_req && i < 50) begin tick(1); i++; end
        check("t4_out_req_wait", out_req, 1);
        ph = phase;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("t4_out_req_held", out_req, 1);
            check("t4_no_mac",       mac_en,  0);
            check("t4_phase_held",   phase,   ph);
        end
        man_out = 1;
        tick(3);
        man_out = 0;
        check("t4_single_count", out_cnt, 1);
        man_in = 0; man_out = 1;
        i = 0;
        while (!in_req && i < 50) begin tick(1); i++; end
        check("t4_in_req_wait", in_req, 1);
        man_out = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("t4_in_req_held",  in_req,   1);
            check("t4_no_mac_in",    mac_en,   0);
            check("t4_no_shift",     shift_en, 0);
            check("t4_phase_fetch",  phase,    134);
        end
        man_in = 1;
        tick(1);
        check("t4_mac_after_ack", mac_en,    1);
        check("t4_clr_after_ack", mac_clr,   1);
        check("t4_coef_after_ack", coef_addr, 134);

        // Reset mid-MAC at tap 2.
        ack_mode = 1;
        do_reset();
        wait_outs(2, 100, "t5_timeout");
        i = 0;
        while (!(mac_en && mac_tap == 2'd2) && i < 20) begin tick(1); i++; end
        check("t5_at_tap2",  mac_tap, 2);
        check("t5_phase_pre", phase,  134);
        rst = 1'b1;
        tick(1);
        check("t5_mac_en", mac_en,  0);
        check("t5_phase",  phase,   0);
        check("t5_out_cnt", out_cnt, 0);
        check("t5_out_req", out_req, 0);
        rst = 1'b0;
        tick(1);
        check("t5_restart_fetch", in_req, 1);
        wait_outs(3, 100, "t5_restart_timeout");
        check("t5_restart_cnt", out_cnt, 3);

        // en dropped during MAC.
        ack_mode = 1;
        do_reset();
        i = 0;
        while (!(mac_en && mn == 1) && i < 50) begin tick(1); i++; end
        check("t6_in_mac", mac_en, 1);
        en = 1'b0;
        wait_outs(2, 50, "t6_complete_timeout");
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("t6_stall_in_req",  in_req,  0);
            check("t6_stall_mac",     mac_en,  0);
            check("t6_stall_out_req", out_req, 0);
            check("t6_stall_phase",   phase,   147);
            check("t6_stall_cnt",     out_cnt, 2);
        end
        en = 1'b1;
        tick(1);
        check("t6_resume_phase",  phase,  134);
        check("t6_resume_in_req", in_req, 1);
        wait_outs(4, 100, "t6_resume_timeout");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/src_phase_sequencer.md
# src_phase_sequencer

Control sequencer for the 160/147 polyphase sample-rate converter. It replaces the in-datapath `(n*M) % L` arithmetic with an incremental phase accumulator and decides when a new input sample must be fetched. It walks the TAPS multiply-accumulate steps for each output, issuing coefficient addresses and tap selects. It owns both req/ack handshakes, so the MAC/delay-line datapath contains no control logic.

## Interface
- L, 160, interpolation factor (number of polyphase branches)
- M, 147, decimation step; M < L required
- TAPS, 4, taps per polyphase branch
- PH_W, 8, phase width; 2^PH_W ≥ L
- CADDR_W, 10, coefficient address width; 2^CADDR_W ≥ L*TAPS
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; sampled only in IDLE and ADVANCE
- in_req  out  1  request for next input sample
- in_ack  in  1  input sample valid on data bus
- shift_en  out  1  delay-line shift strobe, = in_req & in_ack (only combinational output)
- mac_clr  out  1  accumulator load (not add) on tap 0
- mac_en  out  1  MAC step valid
- mac_tap  out  2  delay-line tap select, 0..TAPS-1
- coef_addr  out  CADDR_W  coefficient ROM address = phase + tap*L
- out_req  out  1  accumulator result valid
- out_ack  in  1  output consumer accepted result
- phase  out  PH_W  current polyphase branch
- out_cnt  out  16  outputs delivered, wraps 0xFFFF→0

## Operation
- States: IDLE, FETCH, MAC, DRAIN (macro only), OUTPUT, ADVANCE.
- IDLE: entered from reset. Go to FETCH when en=1.
- FETCH: in_req=1. On in_ack=1, shift_en pulses and the next state is MAC.
- MAC: runs TAPS cycles with tap k=0..TAPS-1. Outputs: mac_en=1, mac_tap=k, coef_addr=phase+k*L. mac_clr=1 on k=0 only.
  - coef_addr is built by adding L each tap; no multiplier.
  - After the last tap, go to DRAIN or OUTPUT.
- OUTPUT: out_req=1. On out_ack=1, out_cnt increments and the next state is ADVANCE.
- ADVANCE: one cycle. Compute s = phase + M.
  - If s ≥ L: phase ← s − L and next state is FETCH.
  - Otherwise: phase ← s and next state is MAC.
  - If en=0, hold in ADVANCE without updating phase until en=1.
- Arithmetic: s is computed at PH_W+1 bits. Because M < L, at most one input is consumed per output.
- Over L outputs the sequence consumes exactly M inputs, and phase returns to its start value.
- in_ack while in_req=0 and out_ack while out_req=0 are ignored. A held ack does not double-count.

## Timing
- Reset values: in_req=0, out_req=0, mac_en=0, mac_clr=0, mac_tap=0, coef_addr=0, phase=0, out_cnt=0, state=IDLE. shift_en=0 because in_req=0.
- All outputs except shift_en are registered Moore outputs of the state and counters.
- in_req rises the cycle after IDLE sees en=1.
- Input handshake at cycle t: MAC occupies t+1..t+TAPS. out_req rises at t+TAPS+1, or t+TAPS+2 with DRAIN.
- Output handshake at cycle u: ADVANCE at u+1. At u+2 either in_req=1 (fetch path) or the first MAC cycle (no-fetch path).
- out_req and in_req hold steady until their ack is sampled and drop the next cycle. No timeout.
- rst in any state, including mid-MAC or with a req pending: next cycle returns to reset values. No partial output is emitted.

## Configuration
- SRC_SEQ_DRAIN_EN defined:
  - DRAIN state inserted for one cycle after the last MAC tap, with mac_en=0.
  - Supports a datapath whose product register adds one cycle before accumulation.
  - out_req follows the last tap by 2 cycles.
- Undefined: no DRAIN; OUTPUT directly follows the last tap, 1 cycle later.

## Test plan
- Reset: hold rst 3 cycles, en=1 → all outputs at reset values; in_req=1 on the first cycle after rst release + 1.
- First outputs with acks tied high: phase across outputs 0,147,134,121,108. Fetch occurs before outputs 0, 2, 3, 4 but not before output 1. coef_addr for output 2 = 134, 294, 454, 614.
- Full period: 160 outputs with random ack delays → exactly 147 shift_en pulses, phase back to 0, out_cnt=160.
- Backpressure: out_ack low 10 cycles during OUTPUT → out_req held, no mac_en, phase unchanged. Same check for in_ack low during FETCH.
- Reset mid-MAC: assert rst at tap 2 → next cycle mac_en=0, phase=0, out_cnt=0; the sequence restarts cleanly from FETCH.
- en=0 asserted during MAC → current output still completes; sequencer stalls in ADVANCE with phase not advanced, and resumes on en=1.
